reg_universal: RTL and testbench
================================

# reg_universal

Parametrised universal register: the successor to the plain enabled D-register bank. Besides hold and parallel load, it clears, increments, decrements, shifts, rotates and arithmetic-shifts in place. It keeps registered carry-out and zero flags. It serves as the accumulator, the shift register or the counter in the PDUA datapath, selected per cycle by the control unit.

## Interface
- `WIDTH`, 8: register width in bits; legal range 2..32.
- `RST_VALUE`, 0: value loaded into `q` on reset; must fit in `WIDTH` bits.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  operation enable; when 0, all state holds regardless of `mode`.
- `mode`  in  4  operation select (encodings below).
- `d`  in  WIDTH  parallel load data.
- `sin`  in  1  serial input for SHL/SHR.
- `q`  out  WIDTH  register contents.
- `cout`  out  1  registered carry/borrow/shifted-out bit.
- `zero`  out  1  registered flag, 1 when `q` == 0.

## Operation
- Priority: `rst` > `en`=0 > `mode`.
- Reset: `q`=`RST_VALUE`, `cout`=0, `zero`=(`RST_VALUE`==0).
- Modes apply when `en`=1; `q` is the current value and `W` is `WIDTH`:
  - 0000 HOLD: no change to `q` or the flags.
  - 0001 LOAD: `q`<=`d`; `cout`<=0.
  - 0010 CLR: `q`<=0; `cout`<=0.
  - 0011 INC: `q`<=`q`+1 mod 2^W; `cout`<=1 only when `q` was all-ones (wrap).
  - 0100 DEC: `q`<=`q`-1 mod 2^W; `cout`<=1 only when `q` was 0 (borrow/wrap).
  - 0101 SHL: `q`<={`q`[W-2:0],`sin`}; `cout`<=`q`[W-1].
  - 0110 SHR: `q`<={`sin`,`q`[W-1:1]}; `cout`<=`q`[0].
  - 0111 ROL: `q`<={`q`[W-2:0],`q`[W-1]}; `cout`<=`q`[W-1].
  - 1000 ROR: `q`<={`q`[0],`q`[W-1:1]}; `cout`<=`q`[0].
  - 1001 ASR: `q`<={`q`[W-1],`q`[W-1:1]}; `cout`<=`q`[0].
  - 1010..1111: reserved; behave exactly as HOLD.
- `zero` is updated together with `q` on every cycle in which `q` is written (LOAD..ASR). It always equals (`q`==0) for the new value. On HOLD, reserved modes and `en`=0, `zero` and `cout` are unchanged.
- All arithmetic is unsigned modulo 2^W; no saturation.
- No combinational path from any input to any output.

## Timing
- Single-cycle operation: the mode sampled at rising edge k determines `q`/`cout`/`zero` immediately after edge k. Latency is 1 clock; one operation per clock; no stall or busy.
- Reset takes effect at the first rising edge with `rst`=1. It overrides an operation requested in the same cycle, including one mid-sequence (e.g. during a shift train). The first operation after reset is sampled at the edge where `rst`=0.
- `en` and `mode` change freely between edges; only values at the edge matter.
- Back-to-back operations chain on the updated `q`; for example INC then SHL yields (`q`+1)<<1.

## Test plan
- Reset with `RST_VALUE`=8'hA5: assert `rst` for 1 cycle while `en`=1, `mode`=INC. Required: `q`=8'hA5, `cout`=0, `zero`=0. Repeat with `RST_VALUE`=0: `zero`=1.
- Counter wrap, W=8: LOAD 8'hFE, then INC, INC. Required: `q`=FF with `cout`=0, then `q`=00 with `cout`=1 and `zero`=1. Follow with DEC: `q`=FF, `cout`=1, `zero`=0.
- Shift/rotate on 8'b1001_0110: SHL with `sin`=1 gives 0010_1101, `cout`=1. SHR with `sin`=0 gives 0100_1011, `cout`=0. ROR gives 0100_1011, `cout`=0. ASR on 8'h80 gives 8'hC0, `cout`=0.
- Enable gating: LOAD 8'h3C, then `en`=0 with `mode` cycling through all 16 codes. Required: `q`=3C, and `cout`/`zero` unchanged every cycle. Then `en`=1 with `mode`=1011..1111: still holds.
- Reset mid-operation: during a run of ROL, assert `rst` for one cycle. Required: `q`=`RST_VALUE` on that edge. ROL resumes from `RST_VALUE` on the next edge.
- Width sweep: WIDTH=2 and WIDTH=32. Required: INC wraps at 2'b11 and 32'hFFFFFFFF with `cout`=1. ASR of the MSB-set value keeps the sign. Reference model compared every cycle over 10k random `en`/`mode`/`d`/`sin`.

Source files
------------

// File: rtl/reg_universal.sv
// Universal register: hold, load, clear, inc/dec, shift, rotate and arithmetic shift in place,
// with registered carry-out and zero flags. One operation per clock, result visible after the edge.

package reg_universal_pkg;
    typedef enum logic [3:0] {
        MODE_HOLD = 4'b0000,
        MODE_LOAD = 4'b0001,
        MODE_CLR  = 4'b0010,
        MODE_INC  = 4'b0011,
        MODE_DEC  = 4'b0100,
        MODE_SHL  = 4'b0101,
        MODE_SHR  = 4'b0110,
        MODE_ROL  = 4'b0111,
        MODE_ROR  = 4'b1000,
        MODE_ASR  = 4'b1001
    } mode_e;
endpackage

// One bit slice: picks the next value of its bit from itself, its neighbours, the load bit
// or the incoming carry/borrow of the ripple chains.
module reg_universal_cell
    import reg_universal_pkg::*;
(
    input  mode_e mode,
    input  logic  cur,
    input  logic  lo,
    input  logic  hi,
    input  logic  ld,
    input  logic  cy,
    input  logic  bw,
    output logic  nxt
);
    always_comb begin
        nxt = cur;
        case (mode)
            MODE_LOAD:                     nxt = ld;
            MODE_CLR:                      nxt = 1'b0;
            MODE_INC:                      nxt = cur ^ cy;
            MODE_DEC:                      nxt = cur ^ bw;
            MODE_SHL, MODE_ROL:            nxt = lo;
            MODE_SHR, MODE_ROR, MODE_ASR:  nxt = hi;
            default:                       nxt = cur;
        endcase
    end
endmodule

module reg_universal
    import reg_universal_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RST_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [3:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             zero
);
    mode_e            op;
    logic [WIDTH-1:0] lo, hi, nxt;
    logic [WIDTH:0]   cy, bw;
    logic             wr, cout_nxt;

    assign op = mode_e'(mode);

    // cy[i]: all bits below i are ones (INC carries into i); bw[i]: all below are zeros (DEC borrows)
    assign cy[0] = 1'b1;
    assign bw[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign cy[i+1] = cy[i] & q[i];
        assign bw[i+1] = bw[i] & ~q[i];

        if (i == 0) begin : g_lo_edge
            assign lo[i] = (op == MODE_ROL) ? q[WIDTH-1] : sin;
        end else begin : g_lo_mid
            assign lo[i] = q[i-1];
        end

        if (i == WIDTH-1) begin : g_hi_edge
            assign hi[i] = (op == MODE_ROR) ? q[0] :
                           (op == MODE_ASR) ? q[WIDTH-1] : sin;
        end else begin : g_hi_mid
            assign hi[i] = q[i+1];
        end

        reg_universal_cell u_cell (
            .mode (op),
            .cur  (q[i]),
            .lo   (lo[i]),
            .hi   (hi[i]),
            .ld   (d[i]),
            .cy   (cy[i]),
            .bw   (bw[i]),
            .nxt  (nxt[i])
        );
    end

    always_comb begin
        wr       = 1'b1;
        cout_nxt = 1'b0;
        case (op)
            MODE_LOAD, MODE_CLR:           cout_nxt = 1'b0;
            MODE_INC:                      cout_nxt = cy[WIDTH];
            MODE_DEC:                      cout_nxt = bw[WIDTH];
            MODE_SHL, MODE_ROL:            cout_nxt = q[WIDTH-1];
            MODE_SHR, MODE_ROR, MODE_ASR:  cout_nxt = q[0];
            default:                       wr       = 1'b0;  // HOLD and reserved codes
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= RST_VALUE;
            cout <= 1'b0;
            zero <= (RST_VALUE == '0);
        end else if (en && wr) begin
            q    <= nxt;
            cout <= cout_nxt;
            zero <= (nxt == '0);
        end
    end
endmodule

// File: tb/tb_reg_universal.sv
// Bench for reg_universal: four instances (8-bit A5/00 reset, 2-bit, 32-bit) share controls and are
// compared every cycle against an arithmetic reference model, plus directed test-plan checks.

module tb_reg_universal;
    logic        clk = 1'b0;
    logic        rst, en, sin;
    logic [3:0]  mode;
    logic [31:0] d_all;

    logic [7:0]  q_a, q_z;
    logic [1:0]  q_n;
    logic [31:0] q_w;
    logic        c_a, c_z, c_n, c_w, z_a, z_z, z_n, z_w;

    int total = 0;
    int bad   = 0;

    int              wid[4] = '{8, 8, 2, 32};
    longint unsigned rv[4]  = '{64'hA5, 64'h0, 64'h1, 64'h8000_0000};
    longint unsigned m_q[4];
    bit              m_c[4], m_z[4];

    always #5 clk = ~clk;

    reg_universal #(.WIDTH(8), .RST_VALUE(8'hA5)) u_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d_all[7:0]), .sin(sin),
        .q(q_a), .cout(c_a), .zero(z_a));
    reg_universal #(.WIDTH(8), .RST_VALUE(8'h00)) u_z (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d_all[7:0]), .sin(sin),
        .q(q_z), .cout(c_z), .zero(z_z));
    reg_universal #(.WIDTH(2), .RST_VALUE(2'b01)) u_n (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d_all[1:0]), .sin(sin),
        .q(q_n), .cout(c_n), .zero(z_n));
    reg_universal #(.WIDTH(32), .RST_VALUE(32'h8000_0000)) u_w (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d_all), .sin(sin),
        .q(q_w), .cout(c_w), .zero(z_w));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    // Reference: next state from the operation table using plain modular arithmetic.
    function automatic void mstep(int i, bit r, bit e, logic [3:0] m, logic [31:0] dv, bit s);
        int              w   = wid[i];
        longint unsigned mk  = (64'd1 << w) - 1;
        longint unsigned v   = m_q[i];
        longint unsigned msb = (v >> (w - 1)) & 1;
        longint unsigned lsb = v & 1;
        longint unsigned sl  = longint'(s);
        longint unsigned nv;
        bit              c;
        if (r) begin
            m_q[i] = rv[i];
            m_c[i] = 1'b0;
            m_z[i] = (rv[i] == 0);
            return;
        end
        if (!e || m == 4'd0 || m > 4'd9) return;
        case (m)
            4'd1: begin nv = longint'(dv) & mk;        c = 1'b0;     end
            4'd2: begin nv = 0;                         c = 1'b0;     end
            4'd3: begin nv = (v + 1) & mk;              c = (v == mk); end
            4'd4: begin nv = (v - 1) & mk;              c = (v == 0); end
            4'd5: begin nv = ((v << 1) | sl) & mk;      c = msb[0];   end
            4'd6: begin nv = (v >> 1) | (sl << (w-1));  c = lsb[0];   end
            4'd7: begin nv = ((v << 1) | msb) & mk;     c = msb[0];   end
            4'd8: begin nv = (v >> 1) | (lsb << (w-1)); c = lsb[0];   end
            default: begin nv = (v >> 1) | (msb << (w-1)); c = lsb[0]; end
        endcase
        m_q[i] = nv;
        m_c[i] = c;
        m_z[i] = (nv == 0);
    endfunction

    task automatic check_all();
        logic [31:0] gq[4];
        logic        gc[4], gz[4];
        gq = '{32'(q_a), 32'(q_z), 32'(q_n), q_w};
        gc = '{c_a, c_z, c_n, c_w};
        gz = '{z_a, z_z, z_n, z_w};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("m_q%0d", i), gq[i], 32'(m_q[i]));
            chk($sformatf("m_c%0d", i), 32'(gc[i]), 32'(m_c[i]));
            chk($sformatf("m_z%0d", i), 32'(gz[i]), 32'(m_z[i]));
        end
    endtask

    task automatic step(input bit r, input bit e, input logic [3:0] m,
                        input logic [31:0] dv, input bit s);
        rst = r; en = e; mode = m; d_all = dv; sin = s;
        @(posedge clk);
        for (int i = 0; i < 4; i++) mstep(i, r, e, m, dv, s);
        #1;
        check_all();
    endtask

    initial begin
        logic sc, sz;
        rst = 1'b1; en = 1'b0; mode = 4'd0; d_all = '0; sin = 1'b0;

        // reset wins over an INC requested in the same cycle
        step(1, 1, 4'd3, 32'h0, 0);
        chk("rst_q_a5", 32'(q_a), 32'hA5);
        chk("rst_c_a5", 32'(c_a), 32'h0);
        chk("rst_z_a5", 32'(z_a), 32'h0);
        chk("rst_z_00", 32'(z_z), 32'h1);

        // counter wrap
        step(0, 1, 4'd1, 32'hFE, 0);
        step(0, 1, 4'd3, 32'h0, 0);
        chk("inc_ff_q", 32'(q_a), 32'hFF);
        chk("inc_ff_c", 32'(c_a), 32'h0);
        step(0, 1, 4'd3, 32'h0, 0);
        chk("wrap_q", 32'(q_a), 32'h00);
        chk("wrap_c", 32'(c_a), 32'h1);
        chk("wrap_z", 32'(z_a), 32'h1);
        step(0, 1, 4'd4, 32'h0, 0);
        chk("dec_q", 32'(q_a), 32'hFF);
        chk("dec_c", 32'(c_a), 32'h1);
        chk("dec_z", 32'(z_a), 32'h0);

        // shifts and rotates
        step(0, 1, 4'd1, 32'h96, 0);
        step(0, 1, 4'd5, 32'h0, 1);
        chk("shl_q", 32'(q_a), 32'h2D);
        chk("shl_c", 32'(c_a), 32'h1);
        step(0, 1, 4'd1, 32'h96, 0);
        step(0, 1, 4'd6, 32'h0, 0);
        chk("shr_q", 32'(q_a), 32'h4B);
        chk("shr_c", 32'(c_a), 32'h0);
        step(0, 1, 4'd1, 32'h96, 0);
        step(0, 1, 4'd8, 32'h0, 1);
        chk("ror_q", 32'(q_a), 32'h4B);
        chk("ror_c", 32'(c_a), 32'h0);
        step(0, 1, 4'd1, 32'h80, 0);
        step(0, 1, 4'd9, 32'h0, 0);
        chk("asr_q", 32'(q_a), 32'hC0);
        chk("asr_c", 32'(c_a), 32'h0);

        // enable gating, then reserved modes
        step(0, 1, 4'd1, 32'h3C, 0);
        sc = c_a; sz = z_a;
        for (int m = 0; m < 16; m++) begin
            step(0, 0, 4'(m), 32'h0, 1);
            chk("gate_q", 32'(q_a), 32'h3C);
            chk("gate_c", 32'(c_a), 32'(sc));
            chk("gate_z", 32'(z_a), 32'(sz));
        end
        for (int m = 11; m < 16; m++) begin
            step(0, 1, 4'(m), 32'h0, 1);
            chk("rsvd_q", 32'(q_a), 32'h3C);
        end

        // reset in the middle of a rotate train
        step(0, 1, 4'd1, 32'h81, 0);
        step(0, 1, 4'd7, 32'h0, 0);
        step(0, 1, 4'd7, 32'h0, 0);
        step(1, 1, 4'd7, 32'h0, 0);
        chk("rol_rst_q", 32'(q_a), 32'hA5);
        step(0, 1, 4'd7, 32'h0, 0);
        chk("rol_resume_q", 32'(q_a), 32'h4B);
        chk("rol_resume_c", 32'(c_a), 32'h1);

        // width extremes
        step(0, 1, 4'd1, 32'hFFFF_FFFF, 0);
        step(0, 1, 4'd3, 32'h0, 0);
        chk("w2_wrap_q", 32'(q_n), 32'h0);
        chk("w2_wrap_c", 32'(c_n), 32'h1);
        chk("w32_wrap_q", q_w, 32'h0);
        chk("w32_wrap_c", 32'(c_w), 32'h1);
        step(0, 1, 4'd1, 32'h8000_0002, 0);
        step(0, 1, 4'd9, 32'h0, 0);
        chk("w2_asr_q", 32'(q_n), 32'h3);
        chk("w32_asr_q", q_w, 32'hC000_0001);
        chk("w32_asr_c", 32'(c_w), 32'h0);

        // randomized run against the model
        for (int n = 0; n < 10000; n++) begin
            step($urandom_range(63) == 0, $urandom_range(3) != 0,
                 4'($urandom_range(15)), $urandom, $urandom_range(1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
